// File: rtl/idu_sb_if.sv
// Decode-stage bus: IFU request side, EXU issue side and WBU write-back port.
// The slave modport is the decode stage; the master modport drives it.
interface idu_sb_if #(
    parameter int XLEN = 32
);
    logic            valid_pre_i;
    logic            ready_pre_o;
    logic [XLEN-1:0] pc_i;
    logic [31:0]     inst_i;
    logic            flush_i;
    logic            valid_post_o;
    logic            ready_post_i;
    logic [XLEN-1:0] pc_o;
    logic [6:0]      opcode_o;
    logic [2:0]      funct3_o;
    logic [6:0]      funct7_o;
    logic [4:0]      rd_o;
    logic            wena_o;
    logic [XLEN-1:0] imm_o;
    logic [XLEN-1:0] rdata1_o;
    logic [XLEN-1:0] rdata2_o;
    logic            illegal_o;
    logic            stall_o;
    logic            wena_i;
    logic [4:0]      waddr_i;
    logic [XLEN-1:0] wdata_i;

    modport slave (
        input  valid_pre_i, pc_i, inst_i, flush_i, ready_post_i,
               wena_i, waddr_i, wdata_i,
        output ready_pre_o, valid_post_o, pc_o, opcode_o, funct3_o, funct7_o,
               rd_o, wena_o, imm_o, rdata1_o, rdata2_o, illegal_o, stall_o
    );

    modport master (
        output valid_pre_i, pc_i, inst_i, flush_i, ready_post_i,
               wena_i, waddr_i, wdata_i,
        input  ready_pre_o, valid_post_o, pc_o, opcode_o, funct3_o, funct7_o,
               rd_o, wena_o, imm_o, rdata1_o, rdata2_o, illegal_o, stall_o
    );
endinterface

// File: rtl/idu_sb.sv
// Decode stage: one-entry buffer, field/immediate decode, register file with
// write-back bypass and a per-register pending-write scoreboard for RAW stalls.
//   state   | meaning
//   S_EMPTY | no instruction held, ready for IFU
//   S_HOLD  | instruction held, presented to EXU unless hazard or flush
module idu_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    idu_sb_if.slave    bus
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_rf  [NREGS];
    logic [CNT_W-1:0] r_cnt [NREGS];

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic            w_use_rd, w_use_rs1, w_use_rs2, w_known;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal, w_wena, w_hazard;
    logic            w_hold, w_valid, w_issue, w_ready_pre, w_accept, w_sb_inc;
    logic [CNT_W-1:0] w_cnt_rs1, w_cnt_rs2, w_cnt_rd;
    logic [XLEN-1:0] w_rf_rs1, w_rf_rs2;
    logic            w_wb_rs1, w_wb_rs2, w_wb_rd;

    function automatic logic in_range(input logic [4:0] idx);
        return {27'b0, idx} < NREGS;
    endfunction

    assign w_opcode = r_inst[6:0];
    assign w_rd     = r_inst[11:7];
    assign w_rs1    = r_inst[19:15];
    assign w_rs2    = r_inst[24:20];

    always_comb begin
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_known   = 1'b1;
        w_imm32   = '0;
        case (w_opcode)
            7'b0110111, 7'b0010111: begin
                w_use_rd = 1'b1;
                w_imm32  = {r_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                w_use_rd = 1'b1;
                w_imm32  = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12],
                            r_inst[20], r_inst[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_imm32   = {{20{r_inst[31]}}, r_inst[31:20]};
            end
            7'b1100011: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm32   = {{19{r_inst[31]}}, r_inst[31], r_inst[7],
                             r_inst[30:25], r_inst[11:8], 1'b0};
            end
            7'b0100011: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm32   = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
            end
            7'b0110011: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

    always_comb begin
        w_imm        = {XLEN{w_imm32[31]}};
        w_imm[31:0]  = w_imm32;
    end

    // Out-of-range indices read as zero data and zero pending count.
    always_comb begin
        w_cnt_rs1 = '0;
        w_cnt_rs2 = '0;
        w_cnt_rd  = '0;
        w_rf_rs1  = '0;
        w_rf_rs2  = '0;
        if (in_range(w_rs1)) begin
            w_cnt_rs1 = r_cnt[w_rs1[AW-1:0]];
            w_rf_rs1  = r_rf[w_rs1[AW-1:0]];
        end
        if (in_range(w_rs2)) begin
            w_cnt_rs2 = r_cnt[w_rs2[AW-1:0]];
            w_rf_rs2  = r_rf[w_rs2[AW-1:0]];
        end
        if (in_range(w_rd)) begin
            w_cnt_rd = r_cnt[w_rd[AW-1:0]];
        end
    end

    assign w_wb_rs1 = bus.wena_i && (bus.waddr_i == w_rs1) && (w_rs1 != 5'd0);
    assign w_wb_rs2 = bus.wena_i && (bus.waddr_i == w_rs2) && (w_rs2 != 5'd0);
    assign w_wb_rd  = bus.wena_i && (bus.waddr_i == w_rd);

    assign w_illegal = !w_known
                       || (w_use_rd  && !in_range(w_rd))
                       || (w_use_rs1 && !in_range(w_rs1))
                       || (w_use_rs2 && !in_range(w_rs2));
    assign w_wena    = w_use_rd && (w_rd != 5'd0);

    // A source whose last outstanding write lands this cycle is satisfied by the bypass.
    assign w_hazard = (w_use_rs1 && (w_rs1 != 5'd0) && (w_cnt_rs1 != '0)
                          && !((w_cnt_rs1 == CNT_W'(1)) && w_wb_rs1))
                   || (w_use_rs2 && (w_rs2 != 5'd0) && (w_cnt_rs2 != '0)
                          && !((w_cnt_rs2 == CNT_W'(1)) && w_wb_rs2))
                   || (w_wena && (&w_cnt_rd) && !w_wb_rd);

    assign w_hold      = (r_state == S_HOLD);
    assign w_valid     = w_hold && !w_hazard && !bus.flush_i;
    assign w_issue     = w_valid && bus.ready_post_i;
    assign w_ready_pre = !w_hold || w_issue || bus.flush_i;
    assign w_accept    = bus.valid_pre_i && w_ready_pre;
    assign w_sb_inc    = w_issue && w_wena && !w_illegal;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_HOLD;
            S_HOLD:  if (bus.flush_i || w_issue)
                         w_state_nxt = w_accept ? S_HOLD : S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_EMPTY;
            r_pc    <= '0;
            r_inst  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_pc   <= bus.pc_i;
                r_inst <= bus.inst_i;
            end
            for (int i = 1; i < NREGS; i++) begin
                if (bus.wena_i && (bus.waddr_i == 5'(i))) begin
                    r_rf[i] <= bus.wdata_i;
                end
                if (w_sb_inc && (w_rd == 5'(i)) && !(bus.wena_i && (bus.waddr_i == 5'(i)))) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (!(w_sb_inc && (w_rd == 5'(i))) && bus.wena_i
                             && (bus.waddr_i == 5'(i)) && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    assign bus.ready_pre_o  = w_ready_pre;
    assign bus.valid_post_o = w_valid;
    assign bus.stall_o      = w_hold && w_hazard;
    assign bus.illegal_o    = w_hold && w_illegal;
    assign bus.wena_o       = w_hold && w_wena;
    assign bus.pc_o         = r_pc;
    assign bus.opcode_o     = w_opcode;
    assign bus.funct3_o     = r_inst[14:12];
    assign bus.funct7_o     = r_inst[31:25];
    assign bus.rd_o         = w_rd;
    assign bus.imm_o        = w_imm;
    assign bus.rdata1_o     = w_wb_rs1 ? bus.wdata_i : w_rf_rs1;
    assign bus.rdata2_o     = w_wb_rs2 ? bus.wdata_i : w_rf_rs2;
endmodule

// File: tb/tb_idu_sb.sv
// Bench for idu_sb: directed scenarios on a 32-register and a 16-register
// instance, then randomized traffic against a queue/array reference model.
module tb_idu_sb;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    idu_sb_if #(.XLEN(32)) bus ();
    idu_sb_if #(.XLEN(32)) bus16 ();

    idu_sb #(.XLEN(32), .NREGS(32), .CNT_W(2)) dut   (.clk(clk), .rst(rst), .bus(bus));
    idu_sb #(.XLEN(32), .NREGS(16), .CNT_W(2)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.valid_pre_i = 0; bus.pc_i = 0; bus.inst_i = 0; bus.flush_i = 0;
        bus.ready_post_i = 0; bus.wena_i = 0; bus.waddr_i = 0; bus.wdata_i = 0;
        bus16.valid_pre_i = 0; bus16.pc_i = 0; bus16.inst_i = 0; bus16.flush_i = 0;
        bus16.ready_post_i = 0; bus16.wena_i = 0; bus16.waddr_i = 0; bus16.wdata_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Reference decode: source usage and immediate value from the ISA rules.
    function automatic void ref_decode(input logic [31:0] ins, output bit urd, output bit u1,
                                       output bit u2, output bit known, output logic [31:0] imm);
        logic signed [31:0] s;
        int v;
        s = $signed(ins);
        urd = 0; u1 = 0; u2 = 0; known = 1; imm = 0; v = 0;
        case (ins[6:0])
            7'h37, 7'h17: begin urd = 1; imm = ins & 32'hFFFF_F000; end
            7'h6F: begin
                urd = 1;
                v = (s >>> 31) * (1 << 20) + int'(ins[19:12]) * (1 << 12)
                    + int'(ins[20]) * (1 << 11) + int'(ins[30:21]) * 2;
                imm = v;
            end
            7'h67, 7'h03, 7'h13, 7'h73: begin urd = 1; u1 = 1; imm = s >>> 20; end
            7'h63: begin
                u1 = 1; u2 = 1;
                v = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                    + int'(ins[11:8]) * 2;
                imm = v;
            end
            7'h23: begin
                u1 = 1; u2 = 1;
                v = (s >>> 25) * 32 + int'(ins[11:7]);
                imm = v;
            end
            7'h33: begin urd = 1; u1 = 1; u2 = 1; end
            default: known = 0;
        endcase
    endfunction

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.valid_post_o !== 1'b0) begin failures++; $display("FAIL reset_valid act=%0b exp=0", bus.valid_post_o); end
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall act=%0b exp=0", bus.stall_o); end
        checks++; if (bus.illegal_o !== 1'b0) begin failures++; $display("FAIL reset_illegal act=%0b exp=0", bus.illegal_o); end
        checks++; if (bus.ready_pre_o !== 1'b1) begin failures++; $display("FAIL reset_ready_pre act=%0b exp=1", bus.ready_pre_o); end
        checks++; if (bus16.illegal_o !== 1'b0) begin failures++; $display("FAIL reset16_illegal act=%0b exp=0", bus16.illegal_o); end
    endtask

    task automatic test_addi();
        @(negedge clk);
        bus.valid_pre_i = 1; bus.pc_i = 32'h8000_0000; bus.inst_i = 32'h0050_0093; bus.ready_post_i = 0;
        #1;
        checks++; if (bus.ready_pre_o !== 1'b1) begin failures++; $display("FAIL addi_ready_pre act=%0b exp=1", bus.ready_pre_o); end
        checks++; if (bus.valid_post_o !== 1'b0) begin failures++; $display("FAIL addi_latency act=%0b exp=0", bus.valid_post_o); end
        @(negedge clk);
        bus.valid_pre_i = 0; bus.ready_post_i = 1;
        #1;
        checks++; if (bus.valid_post_o !== 1'b1) begin failures++; $display("FAIL addi_valid act=%0b exp=1", bus.valid_post_o); end
        checks++; if (bus.rd_o !== 5'd1) begin failures++; $display("FAIL addi_rd act=%0d exp=1", bus.rd_o); end
        checks++; if (bus.imm_o !== 32'd5) begin failures++; $display("FAIL addi_imm act=%0h exp=5", bus.imm_o); end
        checks++; if (bus.wena_o !== 1'b1) begin failures++; $display("FAIL addi_wena act=%0b exp=1", bus.wena_o); end
        checks++; if (bus.rdata1_o !== 32'd0) begin failures++; $display("FAIL addi_rdata1 act=%0h exp=0", bus.rdata1_o); end
        checks++; if (bus.pc_o !== 32'h8000_0000) begin failures++; $display("FAIL addi_pc act=%0h exp=80000000", bus.pc_o); end
        checks++; if (bus.opcode_o !== 7'h13) begin failures++; $display("FAIL addi_opcode act=%0h exp=13", bus.opcode_o); end
    endtask

    task automatic test_raw_bypass();
        @(negedge clk);
        bus.valid_pre_i = 1; bus.inst_i = 32'h0010_8133; bus.pc_i = 32'h8000_0004; bus.ready_post_i = 1;
        @(negedge clk);
        bus.valid_pre_i = 0;
        #1;
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL raw_stall act=%0b exp=1", bus.stall_o); end
        checks++; if (bus.valid_post_o !== 1'b0) begin failures++; $display("FAIL raw_valid act=%0b exp=0", bus.valid_post_o); end
        @(negedge clk);
        #1;
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL raw_stall2 act=%0b exp=1", bus.stall_o); end
        @(negedge clk);
        bus.wena_i = 1; bus.waddr_i = 5'd1; bus.wdata_i = 32'h5;
        #1;
        checks++; if (bus.valid_post_o !== 1'b1) begin failures++; $display("FAIL raw_bypass_valid act=%0b exp=1", bus.valid_post_o); end
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL raw_bypass_stall act=%0b exp=0", bus.stall_o); end
        checks++; if (bus.rdata1_o !== 32'h5) begin failures++; $display("FAIL raw_rdata1 act=%0h exp=5", bus.rdata1_o); end
        checks++; if (bus.rdata2_o !== 32'h5) begin failures++; $display("FAIL raw_rdata2 act=%0h exp=5", bus.rdata2_o); end
        @(negedge clk);
        bus.wena_i = 0;
        #1;
        checks++; if (bus.valid_post_o !== 1'b0) begin failures++; $display("FAIL raw_empty act=%0b exp=0", bus.valid_post_o); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.wena_i = 1; bus.waddr_i = 5'd2; bus.wdata_i = 32'h22;
        bus.valid_pre_i = 1; bus.inst_i = 32'h0071_0193; bus.pc_i = 32'h8000_0008; bus.ready_post_i = 0;
        @(negedge clk);
        bus.wena_i = 0;
        bus.valid_pre_i = 1; bus.inst_i = 32'h0090_0213; bus.pc_i = 32'h8000_000C;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.valid_post_o !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d act=%0b exp=1", k, bus.valid_post_o); end
            checks++; if (bus.ready_pre_o !== 1'b0) begin failures++; $display("FAIL bp_ready_pre cyc=%0d act=%0b exp=0", k, bus.ready_pre_o); end
            checks++; if (bus.rdata1_o !== 32'h22 || bus.imm_o !== 32'd7 || bus.rd_o !== 5'd3 || bus.pc_o !== 32'h8000_0008) begin
                failures++; $display("FAIL bp_stable cyc=%0d act=%0h/%0h/%0d/%0h exp=22/7/3/80000008", k, bus.rdata1_o, bus.imm_o, bus.rd_o, bus.pc_o);
            end
            @(negedge clk);
        end
        bus.ready_post_i = 1;
        #1;
        checks++; if (bus.ready_pre_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_pre act=%0b exp=1", bus.ready_pre_o); end
        @(negedge clk);
        bus.valid_pre_i = 0;
        #1;
        checks++; if (bus.valid_post_o !== 1'b1 || bus.rd_o !== 5'd4 || bus.imm_o !== 32'd9 || bus.pc_o !== 32'h8000_000C) begin
            failures++; $display("FAIL b2b_second act=%0b/%0d/%0h/%0h exp=1/4/9/8000000c", bus.valid_post_o, bus.rd_o, bus.imm_o, bus.pc_o);
        end
        @(negedge clk);
        bus.wena_i = 1; bus.waddr_i = 5'd3; bus.wdata_i = 32'h33;
        @(negedge clk);
        bus.waddr_i = 5'd4; bus.wdata_i = 32'h44;
        @(negedge clk);
        bus.wena_i = 0;
    endtask

    task automatic test_branch();
        @(negedge clk);
        bus.valid_pre_i = 1; bus.inst_i = 32'hFE00_0CE3; bus.pc_i = 32'h8000_0010; bus.ready_post_i = 1;
        @(negedge clk);
        bus.valid_pre_i = 1; bus.inst_i = 32'h019C_8023; bus.pc_i = 32'h8000_0014;
        #1;
        checks++; if (bus.valid_post_o !== 1'b1) begin failures++; $display("FAIL beq_valid act=%0b exp=1", bus.valid_post_o); end
        checks++; if (bus.imm_o !== 32'hFFFF_FFF8) begin failures++; $display("FAIL beq_imm act=%0h exp=fffffff8", bus.imm_o); end
        checks++; if (bus.wena_o !== 1'b0) begin failures++; $display("FAIL beq_wena act=%0b exp=0", bus.wena_o); end
        @(negedge clk);
        bus.valid_pre_i = 0;
        #1;
        checks++; if (bus.valid_post_o !== 1'b1 || bus.stall_o !== 1'b0) begin
            failures++; $display("FAIL beq_sb_unchanged act=%0b/%0b exp=1/0", bus.valid_post_o, bus.stall_o);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        @(negedge clk);
        bus.valid_pre_i = 1; bus.inst_i = 32'h0000_037F; bus.ready_post_i = 1;
        bus16.valid_pre_i = 1; bus16.inst_i = 32'h0010_0A13; bus16.ready_post_i = 1;
        @(negedge clk);
        bus.inst_i = 32'h0063_0023;
        bus16.inst_i = 32'h0042_0023;
        #1;
        checks++; if (bus.illegal_o !== 1'b1 || bus.valid_post_o !== 1'b1) begin failures++; $display("FAIL ill_opcode act=%0b/%0b exp=1/1", bus.illegal_o, bus.valid_post_o); end
        checks++; if (bus.wena_o !== 1'b0) begin failures++; $display("FAIL ill_wena act=%0b exp=0", bus.wena_o); end
        checks++; if (bus16.illegal_o !== 1'b1 || bus16.valid_post_o !== 1'b1) begin failures++; $display("FAIL ill_regidx act=%0b/%0b exp=1/1", bus16.illegal_o, bus16.valid_post_o); end
        @(negedge clk);
        bus.valid_pre_i = 0; bus16.valid_pre_i = 0;
        #1;
        checks++; if (bus.valid_post_o !== 1'b1 || bus.stall_o !== 1'b0 || bus.illegal_o !== 1'b0) begin
            failures++; $display("FAIL ill_sb_unchanged act=%0b/%0b/%0b exp=1/0/0", bus.valid_post_o, bus.stall_o, bus.illegal_o);
        end
        checks++; if (bus16.valid_post_o !== 1'b1 || bus16.stall_o !== 1'b0 || bus16.illegal_o !== 1'b0) begin
            failures++; $display("FAIL ill16_sb_unchanged act=%0b/%0b/%0b exp=1/0/0", bus16.valid_post_o, bus16.stall_o, bus16.illegal_o);
        end
        @(negedge clk);
        bus16.ready_post_i = 0;
    endtask

    task automatic test_flush_and_reset();
        @(negedge clk);
        bus.valid_pre_i = 1; bus.inst_i = 32'h0010_0313; bus.ready_post_i = 1;
        @(negedge clk);
        bus.inst_i = 32'h0063_03B3;
        #1;
        checks++; if (bus.ready_pre_o !== 1'b1 || bus.rd_o !== 5'd6) begin failures++; $display("FAIL fl_refill act=%0b/%0d exp=1/6", bus.ready_pre_o, bus.rd_o); end
        @(negedge clk);
        bus.valid_pre_i = 0;
        #1;
        checks++; if (bus.stall_o !== 1'b1 || bus.valid_post_o !== 1'b0) begin failures++; $display("FAIL fl_stall act=%0b/%0b exp=1/0", bus.stall_o, bus.valid_post_o); end
        @(negedge clk);
        bus.flush_i = 1;
        #1;
        checks++; if (bus.ready_pre_o !== 1'b1 || bus.valid_post_o !== 1'b0) begin failures++; $display("FAIL fl_during act=%0b/%0b exp=1/0", bus.ready_pre_o, bus.valid_post_o); end
        @(negedge clk);
        bus.flush_i = 0;
        #1;
        checks++; if (bus.valid_post_o !== 1'b0 || bus.stall_o !== 1'b0) begin failures++; $display("FAIL fl_empty act=%0b/%0b exp=0/0", bus.valid_post_o, bus.stall_o); end
        @(negedge clk);
        bus.valid_pre_i = 1; bus.inst_i = 32'h0003_0413;
        @(negedge clk);
        bus.valid_pre_i = 0;
        #1;
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL fl_cnt_kept act=%0b exp=1", bus.stall_o); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.valid_post_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.ready_pre_o !== 1'b1) begin
            failures++; $display("FAIL rst_mid_hold act=%0b/%0b/%0b exp=0/0/1", bus.valid_post_o, bus.stall_o, bus.ready_pre_o);
        end
        @(negedge clk);
        bus.valid_pre_i = 1; bus.inst_i = 32'h0013_0433;
        @(negedge clk);
        bus.valid_pre_i = 0;
        #1;
        checks++; if (bus.valid_post_o !== 1'b1 || bus.stall_o !== 1'b0 || bus.rdata2_o !== 32'd0) begin
            failures++; $display("FAIL rst_cleared act=%0b/%0b/%0h exp=1/0/0", bus.valid_post_o, bus.stall_o, bus.rdata2_o);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit          mh;
        logic [31:0] mpc, minst;
        int          mcnt [32];
        logic [31:0] mrf  [32];
        int          wbq  [$];
        logic [6:0]  ops  [12];
        bit          urd, u1, u2, known, haz, v_e, st_e, rp_e, iss, acc, wena_e;
        logic [31:0] imm_e, rd1_e, rd2_e, ins;
        int          rd, rs1, rs2;

        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h63, 7'h23, 7'h33, 7'h7F, 7'h0B};
        do_reset();
        mh = 0; mpc = 0; minst = 0;
        for (int i = 0; i < 32; i++) begin mcnt[i] = 0; mrf[i] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 11)];
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            bus.valid_pre_i  = ($urandom_range(0, 9) < 7);
            bus.inst_i       = ins;
            bus.pc_i         = $urandom & 32'hFFFF_FFFC;
            bus.flush_i      = ($urandom_range(0, 19) == 0);
            bus.ready_post_i = ($urandom_range(0, 9) < 7);
            bus.wdata_i      = $urandom;
            if (wbq.size() > 0 && $urandom_range(0, 1) == 1) begin
                bus.wena_i = 1; bus.waddr_i = 5'(wbq[0]);
            end else if ($urandom_range(0, 19) == 0) begin
                bus.wena_i = 1; bus.waddr_i = 5'd0;
            end else begin
                bus.wena_i = 0; bus.waddr_i = 5'($urandom_range(0, 31));
            end
            #1;
            ref_decode(minst, urd, u1, u2, known, imm_e);
            rd = int'(minst[11:7]); rs1 = int'(minst[19:15]); rs2 = int'(minst[24:20]);
            wena_e = known && urd && (rd != 0);
            haz = 0;
            if (u1 && rs1 != 0 && mcnt[rs1] != 0 && !(mcnt[rs1] == 1 && bus.wena_i && int'(bus.waddr_i) == rs1)) haz = 1;
            if (u2 && rs2 != 0 && mcnt[rs2] != 0 && !(mcnt[rs2] == 1 && bus.wena_i && int'(bus.waddr_i) == rs2)) haz = 1;
            if (wena_e && mcnt[rd] == 3 && !(bus.wena_i && int'(bus.waddr_i) == rd)) haz = 1;
            v_e  = mh && !haz && !bus.flush_i;
            st_e = mh && haz;
            rp_e = !mh || (v_e && bus.ready_post_i) || bus.flush_i;
            rd1_e = (bus.wena_i && int'(bus.waddr_i) == rs1 && rs1 != 0) ? bus.wdata_i : mrf[rs1];
            rd2_e = (bus.wena_i && int'(bus.waddr_i) == rs2 && rs2 != 0) ? bus.wdata_i : mrf[rs2];
            checks++; if (bus.valid_post_o !== v_e || bus.stall_o !== st_e || bus.ready_pre_o !== rp_e) begin
                failures++; $display("FAIL rnd_ctrl cyc=%0d act=%0b/%0b/%0b exp=%0b/%0b/%0b", cyc, bus.valid_post_o, bus.stall_o, bus.ready_pre_o, v_e, st_e, rp_e);
            end
            if (mh) begin
                checks++; if (bus.pc_o !== mpc || bus.opcode_o !== minst[6:0] || bus.rd_o !== minst[11:7]
                              || bus.funct3_o !== minst[14:12] || bus.funct7_o !== minst[31:25]) begin
                    failures++; $display("FAIL rnd_fields cyc=%0d act=%0h/%0h/%0d exp=%0h/%0h/%0d", cyc, bus.pc_o, bus.opcode_o, bus.rd_o, mpc, minst[6:0], minst[11:7]);
                end
                checks++; if (bus.imm_o !== imm_e || bus.illegal_o !== !known || bus.wena_o !== wena_e) begin
                    failures++; $display("FAIL rnd_decode cyc=%0d inst=%0h act=%0h/%0b/%0b exp=%0h/%0b/%0b", cyc, minst, bus.imm_o, bus.illegal_o, bus.wena_o, imm_e, !known, wena_e);
                end
                checks++; if (bus.rdata1_o !== rd1_e || bus.rdata2_o !== rd2_e) begin
                    failures++; $display("FAIL rnd_operands cyc=%0d act=%0h/%0h exp=%0h/%0h", cyc, bus.rdata1_o, bus.rdata2_o, rd1_e, rd2_e);
                end
            end
            iss = v_e && bus.ready_post_i;
            acc = bus.valid_pre_i && rp_e;
            if (bus.wena_i && bus.waddr_i != 5'd0) begin
                if (mcnt[bus.waddr_i] > 0) mcnt[bus.waddr_i]--;
                mrf[bus.waddr_i] = bus.wdata_i;
                void'(wbq.pop_front());
            end
            if (iss && wena_e && known) begin
                mcnt[rd]++;
                wbq.push_back(rd);
            end
            if (!mh || bus.flush_i || iss) mh = acc;
            if (acc) begin minst = bus.inst_i; mpc = bus.pc_i; end
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_addi();
        test_raw_bypass();
        test_back_to_back();
        test_branch();
        test_illegal();
        test_flush_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
